// File: rtl/asi_regfile.sv
// asi_regfile: register-bank responder for the 32-bit register write/read bus.
// Word map: 0 ID, 1 CTRL, 2 SCRATCH, 3 IRQ_STAT (W1C), 4 IRQ_MASK, 5 CNT,
// 6-7 reserved, 8..8+NGP-1 general purpose. Higher indices are out of range.
// Optional feature: define ASI_REGFILE_CNT_EN to implement the CNT cycle
// counter; otherwise word 5 reads 0.
//
// Read FSM states:
//   state  | meaning
//   R_IDLE | waiting for s_rvalid; captures read data/error on it
//   R_RESP | s_rready high for this single cycle, s_rvalid ignored
module asi_regfile #(
    parameter int                AXI_SW     = 3,
    parameter int                REG_AW     = 20,
    parameter int                REG_DW     = 32,
    parameter int                REG_WSTRBW = REG_DW / 8,
    parameter int                L          = $clog2(REG_DW / 8),
    parameter int                NGP        = 8,
    parameter logic [REG_DW-1:0] ID_VALUE   = 32'h4153_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AXI_SW-1:0]     s_wsize,
    input  logic [REG_AW-L-1:0]   s_waddr,
    input  logic [REG_DW-1:0]     s_wdata,
    input  logic [REG_WSTRBW-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic                  s_werr,
    input  logic [AXI_SW-1:0]     s_rsize,
    input  logic [REG_AW-L-1:0]   s_raddr,
    input  logic                  s_rvalid,
    output logic [REG_DW-1:0]     s_rdata,
    output logic                  s_rready,
    output logic                  s_rerr,
    input  logic [7:0]            irq_src,
    output logic [REG_DW-1:0]     ctrl,
    output logic                  irq
);

    localparam int AW = REG_AW - L;
    localparam logic [AW-1:0] A_ID   = AW'(0);
    localparam logic [AW-1:0] A_CTRL = AW'(1);
    localparam logic [AW-1:0] A_SCR  = AW'(2);
    localparam logic [AW-1:0] A_STAT = AW'(3);
    localparam logic [AW-1:0] A_MASK = AW'(4);
    localparam logic [AW-1:0] A_CNT  = AW'(5);
    localparam logic [AW-1:0] A_END  = AW'(8 + NGP);

    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    rstate_e           state_q, state_d;
    logic [REG_DW-1:0] ctrl_q, ctrl_d;
    logic [REG_DW-1:0] scratch_q, scratch_d;
    logic [REG_DW-1:0] gp_q [NGP];
    logic [REG_DW-1:0] gp_d [NGP];
    logic [7:0]        stat_q, stat_d;
    logic [7:0]        mask_q, mask_d;
    logic [7:0]        src_q, src_d;
    logic              irq_q, irq_d;
    logic              wready_q, wready_d;
    logic [REG_DW-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [REG_DW-1:0] cnt_rd;
    logic [REG_DW-1:0] rd_val;
    logic              rd_err;
    logic              wr_ok;
    logic [7:0]        stat_clr;
    logic              unused_wlast;

    // Burst boundaries carry no meaning for a register target.
    assign unused_wlast = s_wlast;

    function automatic logic [REG_DW-1:0] merge_bytes(
        input logic [REG_DW-1:0]     old_v,
        input logic [REG_DW-1:0]     new_v,
        input logic [REG_WSTRBW-1:0] strb
    );
        logic [REG_DW-1:0] r;
        r = old_v;
        for (int k = 0; k < REG_WSTRBW; k++) begin
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    assign s_wready = wready_q;
    assign s_werr   = s_wvalid & ((s_wsize != AXI_SW'(L)) | (s_waddr >= A_END));
    assign wr_ok    = s_wvalid & s_wready & ~s_werr;
    assign s_rready = (state_q == R_RESP);
    assign s_rdata  = rdata_q;
    assign s_rerr   = rerr_q;
    assign ctrl     = ctrl_q;
    assign irq      = irq_q;

`ifdef ASI_REGFILE_CNT_EN
    logic [REG_DW-1:0] cnt_q, cnt_d;

    // Free-running cycle counter gated by CTRL[0]; wraps naturally.
    always_comb begin
        cnt_d = ctrl_q[0] ? cnt_q + REG_DW'(1) : cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_rd = cnt_q;
`else
    assign cnt_rd = '0;
`endif

    // Write decode, byte merge, interrupt edge capture and W1C clear.
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        mask_d    = mask_q;
        gp_d      = gp_q;
        stat_clr  = '0;
        wready_d  = 1'b1;
        if (wr_ok) begin
            case (s_waddr)
                A_CTRL:  ctrl_d    = merge_bytes(ctrl_q, s_wdata, s_wstrb);
                A_SCR:   scratch_d = merge_bytes(scratch_q, s_wdata, s_wstrb);
                A_MASK:  if (s_wstrb[0]) mask_d = s_wdata[7:0];
                A_STAT:  if (s_wstrb[0]) stat_clr = s_wdata[7:0];
                default: begin
                    for (int i = 0; i < NGP; i++) begin
                        if (s_waddr == AW'(8 + i))
                            gp_d[i] = merge_bytes(gp_q[i], s_wdata, s_wstrb);
                    end
                end
            endcase
        end
        src_d  = irq_src;
        // A new rising edge wins over a same-cycle clear.
        stat_d = (stat_q & ~stat_clr) | (irq_src & ~src_q);
        irq_d  = |(stat_q & mask_q);
    end

    // Read mux on pre-write register values.
    always_comb begin
        rd_err = (s_rsize != AXI_SW'(L)) || (s_raddr >= A_END);
        rd_val = '0;
        case (s_raddr)
            A_ID:    rd_val = ID_VALUE;
            A_CTRL:  rd_val = ctrl_q;
            A_SCR:   rd_val = scratch_q;
            A_STAT:  rd_val = REG_DW'(stat_q);
            A_MASK:  rd_val = REG_DW'(mask_q);
            A_CNT:   rd_val = cnt_rd;
            default: begin
                for (int i = 0; i < NGP; i++) begin
                    if (s_raddr == AW'(8 + i)) rd_val = gp_q[i];
                end
            end
        endcase
    end

    // Read FSM next-state and response capture.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            R_IDLE: begin
                if (s_rvalid) begin
                    rdata_d = rd_err ? '0 : rd_val;
                    rerr_d  = rd_err;
                    state_d = R_RESP;
                end
            end
            R_RESP:  state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // State and register-bank flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            ctrl_q    <= '0;
            scratch_q <= '0;
            for (int i = 0; i < NGP; i++) gp_q[i] <= '0;
            stat_q    <= '0;
            mask_q    <= '0;
            src_q     <= '0;
            irq_q     <= 1'b0;
            wready_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            gp_q      <= gp_d;
            stat_q    <= stat_d;
            mask_q    <= mask_d;
            src_q     <= src_d;
            irq_q     <= irq_d;
            wready_q  <= wready_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

endmodule

// File: tb/tb_asi_regfile.sv
// Bench for asi_regfile: directed scenarios plus randomized traffic checked
// against a word-level model of the register map.
module tb_asi_regfile;

    localparam int          NGP = 8;
    localparam int          NW  = 8 + NGP;
    localparam logic [31:0] ID  = 32'h4153_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  s_wsize, s_rsize;
    logic [17:0] s_waddr, s_raddr;
    logic [31:0] s_wdata, s_rdata, ctrl;
    logic [3:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready, s_werr;
    logic        s_rvalid, s_rready, s_rerr;
    logic [7:0]  irq_src;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_ctrl, m_scr;
    logic [31:0] m_gp [NGP];
    logic [7:0]  m_stat, m_mask;

    asi_regfile #(.NGP(NGP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_wsize(s_wsize), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_werr(s_werr),
        .s_rsize(s_rsize), .s_raddr(s_raddr), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .s_rready(s_rready), .s_rerr(s_rerr),
        .irq_src(irq_src), .ctrl(ctrl), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return ID;
        if (idx == 1) return m_ctrl;
        if (idx == 2) return m_scr;
        if (idx == 3) return {24'h0, m_stat};
        if (idx == 4) return {24'h0, m_mask};
        if (idx >= 8 && idx < NW) return m_gp[idx-8];
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_ctrl = '0; m_scr = '0; m_stat = '0; m_mask = '0;
        for (int i = 0; i < NGP; i++) m_gp[i] = '0;
    endtask

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        case (idx)
            1: m_ctrl = bmerge(m_ctrl, d, s);
            2: m_scr  = bmerge(m_scr, d, s);
            3: if (s[0]) m_stat = m_stat & ~d[7:0];
            4: if (s[0]) m_mask = d[7:0];
            default: if (idx >= 8 && idx < NW) m_gp[idx-8] = bmerge(m_gp[idx-8], d, s);
        endcase
    endtask

    // Called at a negedge; one write handshake; returns at the following negedge.
    task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] sz, input string nm);
        logic exp_err;
        exp_err = (sz != 3'd2) || (idx >= NW);
        s_waddr = 18'(idx); s_wdata = d; s_wstrb = s; s_wsize = sz;
        s_wlast = 1'b1; s_wvalid = 1'b1;
        #1;
        checks++;
        if (s_wready !== 1'b1) begin
            errors++; $display("FAIL %s wready: got %b want 1", nm, s_wready);
        end
        checks++;
        if (s_werr !== exp_err) begin
            errors++; $display("FAIL %s werr: got %b want %b", nm, s_werr, exp_err);
        end
        @(posedge clk); @(negedge clk);
        s_wvalid = 1'b0;
        if (!exp_err) m_write(idx, d, s);
        checks++;
        if (ctrl !== m_ctrl) begin
            errors++; $display("FAIL %s ctrl: got %h want %h", nm, ctrl, m_ctrl);
        end
    endtask

    // Called at a negedge; one read transaction; takes two cycles.
    task automatic do_read(input int idx, input logic [2:0] sz, input logic chk_data,
                           input string nm, output logic [31:0] got);
        logic        exp_err;
        logic [31:0] exp_d;
        exp_err = (sz != 3'd2) || (idx >= NW);
        exp_d   = exp_err ? 32'h0 : m_read(idx);
        s_raddr = 18'(idx); s_rsize = sz; s_rvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_rvalid = 1'b0;
        got = s_rdata;
        checks++;
        if (s_rready !== 1'b1) begin
            errors++; $display("FAIL %s rready timeout: got %b want 1", nm, s_rready);
        end
        checks++;
        if (s_rerr !== exp_err) begin
            errors++; $display("FAIL %s rerr: got %b want %b", nm, s_rerr, exp_err);
        end
        if (chk_data) begin
            checks++;
            if (s_rdata !== exp_d) begin
                errors++; $display("FAIL %s rdata: got %h want %h", nm, s_rdata, exp_d);
            end
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (s_rready !== 1'b0) begin
            errors++; $display("FAIL %s rready width: got %b want 0", nm, s_rready);
        end
    endtask

    task automatic chk_irq(input logic want, input string nm);
        checks++;
        if (irq !== want) begin
            errors++; $display("FAIL %s irq: got %b want %b", nm, irq, want);
        end
    endtask

    task automatic test_reset();
        logic [31:0] g;
        rst_n = 1'b0;
        s_wvalid = 0; s_rvalid = 0; s_wsize = 3'd2; s_rsize = 3'd2; s_wlast = 0;
        s_waddr = '0; s_raddr = '0; s_wdata = '0; s_wstrb = '0; irq_src = '0;
        m_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s_wready, s_rready, s_rerr, irq} !== 4'b0000 || s_rdata !== 32'h0 || ctrl !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: got wready=%b rready=%b rerr=%b irq=%b rdata=%h ctrl=%h want all 0",
                     s_wready, s_rready, s_rerr, irq, s_rdata, ctrl);
        end
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        do_read(0, 3'd2, 1'b1, "read_id", g);
    endtask

    task automatic test_strobe();
        logic [31:0] g;
        do_write(2, 32'hFFFF_FFFF, 4'hF, 3'd2, "scr_full");
        do_write(2, 32'h1234_5678, 4'b0101, 3'd2, "scr_strb");
        do_read(2, 3'd2, 1'b1, "scr_merge", g);
        checks++;
        if (g !== 32'hFF34_FF78) begin
            errors++; $display("FAIL scr_merge_const: got %h want ff34ff78", g);
        end
        do_write(8, 32'hA5A5_0F0F, 4'b1001, 3'd2, "gp0_strb");
        do_read(8, 3'd2, 1'b1, "gp0_read", g);
    endtask

    task automatic test_errors();
        logic [31:0] g;
        do_write(NW, 32'hDEAD_BEEF, 4'hF, 3'd2, "wr_oor");
        do_write(2, 32'hDEAD_BEEF, 4'hF, 3'd3, "wr_badsize");
        do_read(2, 3'd2, 1'b1, "scr_unchanged", g);
        do_read(NW, 3'd2, 1'b1, "rd_oor", g);
        do_read(2, 3'd0, 1'b1, "rd_badsize", g);
        do_write(6, 32'h1111_2222, 4'hF, 3'd2, "wr_rsvd");
        do_read(6, 3'd2, 1'b1, "rd_rsvd", g);
        do_write(0, 32'h1111_2222, 4'hF, 3'd2, "wr_id");
        do_read(0, 3'd2, 1'b1, "id_ro", g);
        do_write(5, 32'h1111_2222, 4'hF, 3'd2, "wr_cnt");
        do_read(5, 3'd2, 1'b1, "rd_cnt_idle", g);
        do_read(NW - 1, 3'd2, 1'b1, "rd_last_gp", g);
    endtask

    task automatic test_irq();
        logic [31:0] g;
        do_write(4, 32'h0000_0001, 4'h1, 3'd2, "mask_wr");
        irq_src[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        m_stat[0] = 1'b1;
        chk_irq(1'b0, "irq_t1");
        @(posedge clk); @(negedge clk);
        chk_irq(1'b1, "irq_t2");
        irq_src[0] = 1'b0;
        do_read(3, 3'd2, 1'b1, "stat_set", g);
        irq_src[0] = 1'b1;
        do_write(3, 32'h1, 4'h1, 3'd2, "clr_vs_rise");
        m_stat[0] = 1'b1;
        do_read(3, 3'd2, 1'b1, "stat_set_wins", g);
        chk_irq(1'b1, "irq_set_wins");
        do_write(3, 32'h1, 4'h1, 3'd2, "clr_plain");
        chk_irq(1'b1, "irq_clr_lag");
        @(posedge clk); @(negedge clk);
        chk_irq(1'b0, "irq_cleared");
        do_read(3, 3'd2, 1'b1, "stat_clr", g);
        irq_src = 8'h00;
        @(negedge clk);
        irq_src[1] = 1'b1;
        repeat (3) @(negedge clk);
        m_stat[1] = 1'b1;
        chk_irq(1'b0, "irq_masked_out");
        do_write(3, 32'hFF, 4'hE, 3'd2, "clr_nostrb0");
        do_read(3, 3'd2, 1'b1, "stat_kept", g);
        irq_src = 8'h00;
        do_write(3, 32'hFF, 4'h1, 3'd2, "clr_all");
        do_read(3, 3'd2, 1'b1, "stat_empty", g);
    endtask

    task automatic test_back_to_back();
        int          g;
        logic [31:0] old_v, d;
        g = $urandom_range(0, NGP - 1);
        s_raddr = 18'(8 + g); s_rsize = 3'd2; s_rvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d = $urandom;
            old_v = m_gp[g];
            s_waddr = 18'(8 + g); s_wdata = d; s_wstrb = 4'hF; s_wsize = 3'd2; s_wvalid = 1'b1;
            @(posedge clk); @(negedge clk);
            m_gp[g] = d;
            checks++;
            if (s_rready !== ((k % 2) == 0)) begin
                errors++; $display("FAIL b2b rready k=%0d: got %b want %b", k, s_rready, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                checks++;
                if (s_rdata !== old_v) begin
                    errors++; $display("FAIL b2b rdata k=%0d: got %h want %h", k, s_rdata, old_v);
                end
            end
        end
        s_wvalid = 1'b0; s_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] g;
        int          idx;
        logic [2:0]  sz;
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, NW + 3);
            sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 1) == 0) begin
                do_write(idx, $urandom, 4'($urandom), sz, "rnd_wr");
            end else begin
`ifdef ASI_REGFILE_CNT_EN
                if (idx == 5) idx = 6;
`endif
                do_read(idx, sz, 1'b1, "rnd_rd", g);
            end
        end
    endtask

`ifdef ASI_REGFILE_CNT_EN
    task automatic test_cnt();
        logic [31:0] c0, c1, c2, diff;
        do_write(1, 32'h0, 4'hF, 3'd2, "cnt_stop");
        do_read(5, 3'd2, 1'b0, "cnt_base", c0);
        do_write(1, 32'h1, 4'h1, 3'd2, "cnt_go");
        repeat (99) @(posedge clk);
        @(negedge clk);
        do_write(1, 32'h0, 4'h1, 3'd2, "cnt_halt");
        do_read(5, 3'd2, 1'b0, "cnt_run", c1);
        diff = c1 - c0;
        checks++;
        if (diff < 32'd99 || diff > 32'd101) begin
            errors++; $display("FAIL cnt_100: got %0d want 100+-1", diff);
        end
        do_read(5, 3'd2, 1'b0, "cnt_hold", c2);
        checks++;
        if (c2 !== c1) begin
            errors++; $display("FAIL cnt_stable: got %h want %h", c2, c1);
        end
        do_write(1, 32'h1, 4'h1, 3'd2, "cnt_go2");
        dut.cnt_q <= 32'hFFFF_FFF0;
        repeat (40) @(negedge clk);
        do_write(1, 32'h0, 4'h1, 3'd2, "cnt_halt2");
        do_read(5, 3'd2, 1'b0, "cnt_wrap", c1);
        checks++;
        if (c1 == 32'h0 || c1 > 32'd64) begin
            errors++; $display("FAIL cnt_wrap: got %h want small wrapped value", c1);
        end
    endtask
`endif

    task automatic test_reset_mid_read();
        logic [31:0] g;
        do_write(2, 32'hCAFE_F00D, 4'hF, 3'd2, "pre_rst_scr");
        do_write(1, 32'h0000_00F0, 4'hF, 3'd2, "pre_rst_ctrl");
        s_raddr = 18'd2; s_rsize = 3'd2; s_rvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_rvalid = 1'b0;
        checks++;
        if (s_rready !== 1'b1 || s_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL midrd pre: got rready=%b rdata=%h want 1 cafef00d", s_rready, s_rdata);
        end
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if (s_rready !== 1'b0 || s_rdata !== 32'h0 || ctrl !== 32'h0 || s_wready !== 1'b0) begin
            errors++;
            $display("FAIL midrd reset: got rready=%b rdata=%h ctrl=%h wready=%b want 0",
                     s_rready, s_rdata, ctrl, s_wready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        do_read(2, 3'd2, 1'b1, "scr_after_rst", g);
        chk_irq(1'b0, "irq_after_rst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_strobe();
        test_errors();
        test_irq();
        test_back_to_back();
        test_random();
`ifdef ASI_REGFILE_CNT_EN
        test_cnt();
`endif
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
